// File: rtl/serial_pkg.sv
// Shared serial-link definitions used by both ends of the link:
// frame levels, data width and receiver FSM encoding.
package serial_pkg;

    localparam int   DATA_BITS   = 8;
    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = S_IDLE,
        ST_START = S_START,
        ST_DATA  = S_DATA,
        ST_STOP  = S_STOP
    } rx_state_t;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/serial_sync.sv
// Multi-stage synchronizer for the asynchronous serial line.
// Resets to the idle level so that reset never looks like a start bit.
module serial_sync
    import serial_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic i_d,
    output logic o_q
);

    logic [SYNC_STAGES-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync <= {SYNC_STAGES{IDLE_LEVEL}};
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/serial_receiver.sv
// Oversampling UART-style receiver: 8N1 frames, majority vote over three
// mid-bit samples, one-cycle valid / frame_err strobes.
module serial_receiver
    import serial_pkg::*;
#(
    parameter int OVERSAMPLE  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] byte_out,
    output logic                 valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int M    = OVERSAMPLE / 2;
    localparam int PH_W = $clog2(OVERSAMPLE);

    localparam logic [PH_W-1:0] PH_ONE  = PH_W'(1);
    localparam logic [PH_W-1:0] PH_A    = PH_W'(M - 1);
    localparam logic [PH_W-1:0] PH_B    = PH_W'(M);
    localparam logic [PH_W-1:0] PH_VOTE = PH_W'(M + 1);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(OVERSAMPLE - 1);
    localparam logic [2:0]      BIT_LAST = 3'(DATA_BITS - 1);

    logic                 w_rx_s;
    logic                 w_maj;
    logic                 w_start;
    logic                 w_at_vote;
    logic                 w_at_last;

    rx_state_t            r_state;
    rx_state_t            w_state_nxt;
    logic [PH_W-1:0]      r_phase;
    logic [PH_W-1:0]      w_phase_nxt;
    logic [2:0]           r_bit_idx;
    logic [2:0]           w_bit_nxt;
    logic                 w_shift_en;
    logic                 w_valid_nxt;
    logic                 w_err_nxt;

    logic                 r_rx_d;
    logic                 r_smp_a;
    logic                 r_smp_b;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_byte;
    logic                 r_valid;
    logic                 r_frame_err;

    serial_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .i_d   (rx),
        .o_q   (w_rx_s)
    );

    // Edge-based start detection: a line stuck low never re-triggers.
    assign w_start   = (r_rx_d == IDLE_LEVEL) && (w_rx_s == START_LEVEL);
    assign w_maj     = majority3(r_smp_a, r_smp_b, w_rx_s);
    assign w_at_vote = (r_phase == PH_VOTE);
    assign w_at_last = (r_phase == PH_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_phase   <= '0;
            r_bit_idx <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_phase   <= w_phase_nxt;
            r_bit_idx <= w_bit_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = w_at_last ? '0 : r_phase + PH_ONE;
        w_bit_nxt   = r_bit_idx;
        w_shift_en  = 1'b0;
        w_valid_nxt = 1'b0;
        w_err_nxt   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_phase_nxt = '0;
                if (w_start) begin
                    w_state_nxt = ST_START;
                    w_phase_nxt = PH_ONE;
                end
            end
            ST_START: begin
                if (w_at_vote && (w_maj == IDLE_LEVEL)) begin
                    w_state_nxt = ST_IDLE;
                    w_phase_nxt = '0;
                end else if (w_at_last) begin
                    w_state_nxt = ST_DATA;
                    w_bit_nxt   = '0;
                end
            end
            ST_DATA: begin
                w_shift_en = w_at_vote;
                if (w_at_last) begin
                    if (r_bit_idx == BIT_LAST) begin
                        w_state_nxt = ST_STOP;
                        w_bit_nxt   = '0;
                    end else begin
                        w_bit_nxt = r_bit_idx + 3'd1;
                    end
                end
            end
            ST_STOP: begin
                // Leave mid stop bit so the next start edge is never missed.
                if (w_at_vote) begin
                    w_state_nxt = ST_IDLE;
                    w_phase_nxt = '0;
                    w_valid_nxt = (w_maj == STOP_LEVEL);
                    w_err_nxt   = (w_maj != STOP_LEVEL);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_phase_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (r_phase == PH_A) begin
            r_smp_a <= w_rx_s;
        end
        if (r_phase == PH_B) begin
            r_smp_b <= w_rx_s;
        end
        if (w_shift_en) begin
            r_shift <= {w_maj, r_shift[DATA_BITS-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_d      <= IDLE_LEVEL;
            r_byte      <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_rx_d      <= w_rx_s;
            r_valid     <= w_valid_nxt;
            r_frame_err <= w_err_nxt;
            if (w_valid_nxt) begin
                r_byte <= r_shift;
            end
        end
    end

    assign byte_out  = r_byte;
    assign valid     = r_valid;
    assign frame_err = r_frame_err;
    assign busy      = (r_state != ST_IDLE);

endmodule
